regfile_rr_arbiter: RTL
=======================

Name: regfile_rr_arbiter

Overview:
- Shares one 4-entry x 4-bit, 1-read/1-write flat register file between two requesters.
- Register file has a combinational read port and a synchronous write port.
- Each requester uses a val/rdy request channel (read or write) and a val/rdy response channel backed by a 1-entry response buffer.
- Round-robin arbitration grants at most one access per cycle; placed in front of the regfile in small memory-subsystem labs.

Parameters:
- None. Fixed at 2 requesters, 2-bit address, 4-bit data.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
req0_val / req1_val  input  1  request valid, requester 0/1
req0_rdy / req1_rdy  output  1  request accepted this cycle (grant)
req0_type / req1_type  input  1  0 = read, 1 = write
req0_addr / req1_addr  input  2  register index
req0_data / req1_data  input  4  write data (ignored for reads)
resp0_val / resp1_val  output  1  response buffer full
resp0_rdy / resp1_rdy  input  1  requester consumes response
resp0_data / resp1_data  output  4  read data; 0 for write responses
rf_wen  output  1  regfile write enable
rf_waddr  output  2  regfile write address
rf_wdata  output  4  regfile write data
rf_raddr  output  2  regfile read address
rf_rdata  input  4  regfile read data (combinational from rf_raddr)

Behaviour:
- State:
  - prio (1b): which requester wins a tie.
  - Per requester, respN_full (EMPTY/FULL) and respN_data (4b).
- Reset (rst=0, asynchronous):
  - prio=0; both buffers EMPTY; respN_val=0; respN_data=0.
  - While rst=0, reqN_rdy=0 and rf_wen=0.
- Eligibility: requester N is eligible when reqN_val=1 and (respN_full=0 or respN_rdy=1). A full buffer drained this cycle may be refilled in the same cycle.
- Grant:
  - Only one eligible -> it wins.
  - Both eligible -> requester prio wins.
  - reqN_rdy=1 only for the winner; purely combinational from state and inputs.
- Priority update: on a grant to N, prio <= ~N at the edge. No grant -> prio unchanged.
- Regfile drive (combinational):
  - rf_raddr = winner's addr on a read grant, else 0.
  - rf_wen=1, rf_waddr, rf_wdata = winner's addr/data on a write grant. Otherwise rf_wen=0 and waddr/wdata=0.
- Response:
  - At the grant edge, winner's buffer <= FULL.
  - respN_data <= rf_rdata for a read, 0 for a write.
  - Response latency: exactly 1 cycle after acceptance.
- Dequeue: respN_val=1 and respN_rdy=1 with no new grant to N -> buffer EMPTY at edge. A simultaneous dequeue and grant leaves it FULL with new data.
- Ordering: a write accepted in cycle C is visible to any read accepted in cycle C+1 or later, from either requester. Write-then-read to the same address completes in 2 cycles.
- Backpressure: with respN_rdy held 0 and buffer FULL, requester N is never granted. Other requester gets every cycle (no starvation of the ready side).
- Fairness: both requesters continuously eligible -> grants alternate 0,1,0,1... starting with 0 after reset.
- Reset mid-operation: buffered responses are discarded. A write whose edge is not reached before rst falls is not committed (rf_wen forced 0).
- Unknowns: reqN_type/addr/data are don't-care when reqN_val=0; outputs must not depend on them.

Test Plan:
- Reset: hold rst=0 two cycles with req0_val=1 -> req0_rdy=0, rf_wen=0, resp0_val=resp1_val=0. Release -> first grant goes to requester 0.
- Write/read single requester: req0 write addr 2 data 0xA (cycle C) -> rf_wen=1, rf_waddr=2, rf_wdata=0xA in C; resp0_val=1, resp0_data=0 in C+1. Then req0 read addr 2 -> resp0_data=0xA one cycle later.
- Contention: both requesters read every cycle with resp_rdy=1, addrs 0/1 preloaded with 0x3/0x5 -> grants alternate 0,1,0,1. Responses 0x3 and 0x5 appear on the matching port one cycle after each grant.
- Backpressure: resp1_rdy=0 after one read by requester 1 -> resp1_val stays 1 with stable data, req1_rdy=0. Requester 0 granted every cycle. Set resp1_rdy=1 -> requester 1 dequeued and regranted the same cycle.
- Cross-requester ordering: req1 writes addr 3 = 0xF in cycle C; req0 reads addr 3 in C+1 -> resp0_data=0xF in C+2.
- Async reset mid-op: assert rst=0 between edges while resp0_val=1 and req1 write pending -> resp0_val drops immediately. Regfile addr untouched (prior value read back after reset).

Source files
------------

// File: rtl/regfile_rr_arbiter.sv
// regfile_rr_arbiter: round-robin arbiter sharing one 4x4 1R/1W register file between two
// val/rdy requesters, each with a 1-entry response buffer.
module regfile_rr_arbiter (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0_val,
    output logic       o_req0_rdy,
    input  logic       i_req0_type,
    input  logic [1:0] i_req0_addr,
    input  logic [3:0] i_req0_data,
    input  logic       i_req1_val,
    output logic       o_req1_rdy,
    input  logic       i_req1_type,
    input  logic [1:0] i_req1_addr,
    input  logic [3:0] i_req1_data,
    output logic       o_resp0_val,
    input  logic       i_resp0_rdy,
    output logic [3:0] o_resp0_data,
    output logic       o_resp1_val,
    input  logic       i_resp1_rdy,
    output logic [3:0] o_resp1_data,
    output logic       o_rf_wen,
    output logic [1:0] o_rf_waddr,
    output logic [3:0] o_rf_wdata,
    output logic [1:0] o_rf_raddr,
    input  logic [3:0] i_rf_rdata
);
    logic       r_prio;
    logic       r_full0, r_full1;
    logic [3:0] r_data0, r_data1;
    logic       w_elig0, w_elig1, w_g0, w_g1, w_any, w_type;
    logic [1:0] w_addr;
    logic [3:0] w_data;

    // a full buffer being drained this cycle can accept a new response
    assign w_elig0 = i_req0_val & (~r_full0 | i_resp0_rdy);
    assign w_elig1 = i_req1_val & (~r_full1 | i_resp1_rdy);
    assign w_g0    = i_rst_n & w_elig0 & (~w_elig1 | ~r_prio);
    assign w_g1    = i_rst_n & w_elig1 & (~w_elig0 | r_prio);
    assign w_any   = w_g0 | w_g1;

    // winner's fields are zeroed when idle so outputs never see unqualified request inputs
    assign w_type = w_g0 ? i_req0_type : (w_g1 & i_req1_type);
    assign w_addr = w_g0 ? i_req0_addr : (w_g1 ? i_req1_addr : 2'd0);
    assign w_data = w_g0 ? i_req0_data : (w_g1 ? i_req1_data : 4'd0);

    assign o_req0_rdy   = w_g0;
    assign o_req1_rdy   = w_g1;
    assign o_rf_wen     = w_any & w_type;
    assign o_rf_waddr   = o_rf_wen ? w_addr : 2'd0;
    assign o_rf_wdata   = o_rf_wen ? w_data : 4'd0;
    assign o_rf_raddr   = (w_any & ~w_type) ? w_addr : 2'd0;
    assign o_resp0_val  = r_full0;
    assign o_resp1_val  = r_full1;
    assign o_resp0_data = r_data0;
    assign o_resp1_data = r_data1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio  <= 1'b0;
            r_full0 <= 1'b0;
            r_full1 <= 1'b0;
            r_data0 <= 4'd0;
            r_data1 <= 4'd0;
        end else begin
            r_prio  <= w_g0 ? 1'b1 : (w_g1 ? 1'b0 : r_prio);
            r_full0 <= w_g0 | (r_full0 & ~i_resp0_rdy);
            r_full1 <= w_g1 | (r_full1 & ~i_resp1_rdy);
            r_data0 <= w_g0 ? (w_type ? 4'd0 : i_rf_rdata) : r_data0;
            r_data1 <= w_g1 ? (w_type ? 4'd0 : i_rf_rdata) : r_data1;
        end
    end
endmodule
